// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: round-robin AHB bus arbiter for NUM_MASTERS masters.
//
// Grants move only at legal transfer boundaries. A 4-bit beat counter tracks the
// remaining beats of defined-length bursts, and a flag tracks undefined-length INCR
// bursts. Locked masters keep the bus until they drop hlock. hmaster selects the
// address mux. hmaster_data lags it by one accepted transfer and selects the
// write-data mux.
//
// Optional feature (macro AHB_ARB_TIMEOUT_EN): a tenure counter forces
// re-arbitration after MAX_TENURE hready-high cycles when another master is waiting.
// This preempts undefined-length INCR bursts.
//
// Ports:
//   hclk, hresetn  clock, asynchronous active-low reset
//   req, hlock     per-master bus request and lock request
//   hready         muxed slave hreadyout; all state advances only when it is high
//   htrans, hburst address-phase transfer type and burst type
//   hgrant         one-hot grant
//   hmaster        address-phase owner index
//   hmaster_data   data-phase owner index
//   hmastlock      a locked sequence is in progress
module ahb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_TENURE     = 16,
  localparam int unsigned MW            = $clog2(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic                   hready,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_data,
  output logic                   hmastlock
);

  localparam logic [1:0] HtIdle   = 2'b00;
  localparam logic [1:0] HtBusy   = 2'b01;
  localparam logic [1:0] HtNonseq = 2'b10;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || DEFAULT_MASTER >= NUM_MASTERS ||
      MAX_TENURE < 2) begin : gen_bad_param
    $error("ahb_rr_arbiter: illegal parameter combination");
  end

  logic [MW-1:0] hmaster_q, hmaster_d;
  logic [MW-1:0] hmaster_data_q;
  logic          hmastlock_q, hmastlock_d;
  logic [3:0]    rem_q, rem_d;
  logic          undef_q, undef_d;

  logic          lock_hold;
  logic          arb_ok;
  logic          force_arb;
  logic          arb;
  logic [MW-1:0] winner;

  assign lock_hold = hlock[hmaster_q];

  // Beat tracking: remaining beats after the transfer accepted at this edge.
  always_comb begin
    rem_d   = rem_q;
    undef_d = undef_q;
    unique case (htrans)
      HtIdle: begin
        rem_d   = 4'd0;
        undef_d = 1'b0;
      end
      HtBusy: begin
        rem_d   = rem_q;
      end
      HtNonseq: begin
        undef_d = 1'b0;
        case (hburst)
          3'b000:         rem_d = 4'd0;
          3'b001: begin
            rem_d   = 4'd0;
            undef_d = 1'b1;
          end
          3'b010, 3'b011: rem_d = 4'd3;
          3'b100, 3'b101: rem_d = 4'd7;
          default:        rem_d = 4'd15;
        endcase
      end
      default: begin
        rem_d = (rem_q == 4'd0) ? 4'd0 : rem_q - 4'd1;
      end
    endcase
    // An INCR burst ends as soon as its owner stops requesting.
    if (!req[hmaster_q]) begin
      undef_d = 1'b0;
    end
  end

  assign arb_ok = hready & (rem_d == 4'd0) & ~undef_d & ~lock_hold & (htrans != HtBusy);

  // Round-robin scan starting just after the current owner. The current owner is
  // visited last, so it keeps the bus only when nobody else is requesting.
  always_comb begin
    int unsigned   idx;
    logic [MW-1:0] cand;
    logic          found;
    winner = MW'(DEFAULT_MASTER);
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx = 32'(hmaster_q) + i;
      if (idx >= NUM_MASTERS) begin
        idx = idx - NUM_MASTERS;
      end
      cand = MW'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(MAX_TENURE) + 1;
  localparam logic [TW-1:0] TenureLast = TW'(MAX_TENURE - 1);

  logic [TW-1:0]          tenure_q, tenure_d;
  logic [NUM_MASTERS-1:0] other_req;

  always_comb begin
    other_req = req & ~hgrant;
    force_arb = hready & (tenure_q == TenureLast) & (|other_req) & ~lock_hold &
                (rem_d == 4'd0);
  end

  always_comb begin
    tenure_d = tenure_q;
    if (arb && (winner != hmaster_q)) begin
      tenure_d = '0;
    end else if (tenure_q != TenureLast) begin
      tenure_d = tenure_q + 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      tenure_q <= '0;
    end else if (hready) begin
      tenure_q <= tenure_d;
    end
  end
`else
  assign force_arb = 1'b0;
`endif

  assign arb = arb_ok | force_arb;

  always_comb begin
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (arb) begin
      hmaster_d   = winner;
      hmastlock_d = hlock[winner];
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hmaster_q      <= MW'(DEFAULT_MASTER);
      hmaster_data_q <= MW'(DEFAULT_MASTER);
      hmastlock_q    <= 1'b0;
      rem_q          <= 4'd0;
      undef_q        <= 1'b0;
    end else if (hready) begin
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_q;
      hmastlock_q    <= hmastlock_d;
      rem_q          <= rem_d;
      undef_q        <= undef_d;
    end
  end

  // Grant is decoded from the owner index, so it is one-hot by construction.
  always_comb begin
    hgrant = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      hgrant[i] = (hmaster_q == MW'(i));
    end
  end

  assign hmaster      = hmaster_q;
  assign hmaster_data = hmaster_data_q;
  assign hmastlock    = hmastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
module tb_ahb_rr_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [3:0] req, hlock;
  logic       hready;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic [3:0] hgrant;
  logic [1:0] hmaster, hmaster_data;
  logic       hmastlock;

  int errors = 0;
  int checks = 0;

  ahb_rr_arbiter #(
    .NUM_MASTERS   (4),
    .DEFAULT_MASTER(0),
    .MAX_TENURE    (16)
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .req         (req),
    .hlock       (hlock),
    .hready      (hready),
    .htrans      (htrans),
    .hburst      (hburst),
    .hgrant      (hgrant),
    .hmaster     (hmaster),
    .hmaster_data(hmaster_data),
    .hmastlock   (hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected owner m: one-hot grant and matching index.
  task automatic own(input string tag, input int m);
    logic [3:0] one;
    one = 4'b0001;
    chk({tag, "_grant"}, 32'(hgrant), 32'(one << m));
    chk({tag, "_hmaster"}, 32'(hmaster), 32'(m));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                     input logic [1:0] t, input logic [2:0] b);
    req    = r;
    hlock  = l;
    hready = rdy;
    htrans = t;
    hburst = b;
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hresetn = 1'b0;
    req     = '0;
    hlock   = '0;
    hready  = 1'b1;
    htrans  = IDLE;
    hburst  = SINGLE;
    repeat (2) @(posedge hclk);
    #1;
    // Reset state
    own("rst", 0);
    chk("rst_data", 32'(hmaster_data), 0);
    chk("rst_lock", 32'(hmastlock), 0);
    hresetn = 1'b1;

    // Round robin between masters 1 and 2 with SINGLE transfers
    cyc(4'b0110, 4'b0000, 1'b1, NONSEQ, SINGLE);
    own("rr1", 1);
    chk("rr1_data", 32'(hmaster_data), 0);
    cyc(4'b0110, 4'b0000, 1'b1, NONSEQ, SINGLE);
    own("rr2", 2);
    chk("rr2_data", 32'(hmaster_data), 1);
    cyc(4'b0110, 4'b0000, 1'b1, NONSEQ, SINGLE);
    own("rr3", 1);
    chk("rr3_data", 32'(hmaster_data), 2);
    cyc(4'b0110, 4'b0000, 1'b1, NONSEQ, SINGLE);
    own("rr4", 2);
    chk("rr4_data", 32'(hmaster_data), 1);
    cyc(4'b0110, 4'b0000, 1'b1, NONSEQ, SINGLE);
    own("rr5", 1);

    // INCR4 by owner 1 with a wait state on beat 2; hlock[2] is set on the last beat
    cyc(4'b1111, 4'b0000, 1'b1, NONSEQ, INCR4);
    own("b4_ns", 1);
    chk("b4_ns_data", 32'(hmaster_data), 1);
    cyc(4'b1111, 4'b0000, 1'b1, SEQ, INCR4);
    own("b4_s1", 1);
    cyc(4'b1111, 4'b0000, 1'b0, SEQ, INCR4);
    own("b4_stall", 1);
    chk("b4_stall_data", 32'(hmaster_data), 1);
    cyc(4'b1111, 4'b0000, 1'b1, SEQ, INCR4);
    own("b4_s2", 1);
    cyc(4'b1111, 4'b0100, 1'b1, SEQ, INCR4);
    own("b4_s3", 2);
    chk("b4_s3_lock", 32'(hmastlock), 1);

    // Locked sequence by master 2
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 4'b0100, 1'b1, NONSEQ, SINGLE);
      own("lock", 2);
      chk("lock_mastlock", 32'(hmastlock), 1);
    end
    chk("lock_data", 32'(hmaster_data), 2);
    cyc(4'b1111, 4'b0000, 1'b1, NONSEQ, SINGLE);
    own("unlock", 3);
    chk("unlock_mastlock", 32'(hmastlock), 0);

    // No requests: park on the default master
    cyc(4'b0000, 4'b0000, 1'b1, IDLE, SINGLE);
    own("park", 0);
    chk("park_data", 32'(hmaster_data), 3);

    // Undefined-length INCR by master 1 while master 3 waits
    cyc(4'b1010, 4'b0000, 1'b1, NONSEQ, SINGLE);
    own("incr_grant", 1);
    cyc(4'b1010, 4'b0000, 1'b1, NONSEQ, INCR);
    own("incr_ns", 1);
    for (int i = 0; i < 14; i++) begin
      cyc(4'b1010, 4'b0000, 1'b1, SEQ, INCR);
    end
    own("incr_k15", 1);
    cyc(4'b1010, 4'b0000, 1'b1, SEQ, INCR);
`ifdef AHB_ARB_TIMEOUT_EN
    own("incr_k16", 3);
    cyc(4'b1010, 4'b0000, 1'b1, IDLE, SINGLE);
    own("incr_idle", 1);
`else
    own("incr_k16", 1);
    cyc(4'b1010, 4'b0000, 1'b1, IDLE, SINGLE);
    own("incr_idle", 3);
`endif

    // Asynchronous reset in the middle of an INCR4 burst
    cyc(4'b1111, 4'b0000, 1'b1, NONSEQ, INCR4);
    #3;
    hresetn = 1'b0;
    #1;
    own("arst", 0);
    chk("arst_data", 32'(hmaster_data), 0);
    chk("arst_lock", 32'(hmastlock), 0);
    #1;
    hresetn = 1'b1;
    // Beat counter was cleared, so a stray SEQ is already an arbitration point
    cyc(4'b0010, 4'b0000, 1'b1, SEQ, INCR4);
    own("post_rst", 1);
    chk("post_rst_data", 32'(hmaster_data), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
